// File: rtl/i2c_wr_engine_if.sv
// rtl/i2c_wr_engine_if.sv - request/response and I2C pin bundle for the write engine
// Purpose: groups the transaction request inputs, status outputs and I2C pins.
// Ports: addr, num_wr_bytes, wr_data0..2, start (request side); done, busy,
//        ack_err (status); sclk, sdata_out, sdata_oe_n, sdata_in (I2C pins).
// master: the engine itself. slave: the requester / bus model facing it.
`timescale 1ns/1ps
interface i2c_wr_engine_if;
  logic [6:0] addr;
  logic [1:0] num_wr_bytes;
  logic [7:0] wr_data0;
  logic [7:0] wr_data1;
  logic [7:0] wr_data2;
  logic       start;
  logic       done;
  logic       busy;
  logic       ack_err;
  logic       sclk;
  logic       sdata_out;
  logic       sdata_oe_n;
  logic       sdata_in;

  modport master (
    input  addr, num_wr_bytes, wr_data0, wr_data1, wr_data2, start, sdata_in,
    output done, busy, ack_err, sclk, sdata_out, sdata_oe_n
  );

  modport slave (
    output addr, num_wr_bytes, wr_data0, wr_data1, wr_data2, start, sdata_in,
    input  done, busy, ack_err, sclk, sdata_out, sdata_oe_n
  );
endinterface

// File: rtl/i2c_wr_engine.sv
// rtl/i2c_wr_engine.sv - I2C master write engine: address byte plus 0..3 data bytes
// Purpose: on an accepted start, emits START, {addr,0}, num_wr_bytes data bytes
//          (MSB first, ACK slot after each), STOP, then a one-cycle done pulse.
// Ports: clk, reset_n (async, active low); bus (i2c_wr_engine_if.master):
//        request inputs, done/busy/ack_err status, sclk/sdata_out/sdata_oe_n/sdata_in.
// I2C clock = clk / 2^(CLK_DIV_BITS+1); one quarter-bit = 2^(CLK_DIV_BITS-1) clk.
`timescale 1ns/1ps
module i2c_wr_engine #(
  parameter int CLK_DIV_BITS = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  i2c_wr_engine_if.master    bus
);

  // phase spans one full bit (4 quarters): the top two bits are the quarter
  // index, the rest count clk cycles inside the quarter. Natural binary wrap
  // keeps every quarter exactly Q cycles with no drift.
  localparam int PW = CLK_DIV_BITS + 1;
  localparam logic [PW-1:0] PHASE_ONE = PW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BIT   = 3'd2,
    S_ACK   = 3'd3,
    S_STOP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [PW-1:0] phase;
  logic [1:0]    quarter;
  logic          q_end;
  logic          bit_end;

  logic [1:0]    num_r;
  logic [7:0]    d0_r;
  logic [7:0]    d1_r;
  logic [7:0]    d2_r;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_idx;
  logic          ack_err_r;
  logic [7:0]    next_byte;

  logic          sclk_c;
  logic          sda_c;

  assign quarter = phase[PW-1:PW-2];
  assign q_end   = &phase[PW-3:0];
  assign bit_end = &phase;

  // State register; phase restarts on every state change and stays zero in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      phase <= '0;
    end else begin
      state <= state_n;
      if (state_n != state || state == S_IDLE)
        phase <= '0;
      else
        phase <= phase + PHASE_ONE;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (bus.start) state_n = S_START;
      S_START: if (quarter == 2'd1 && q_end) state_n = S_BIT;
      S_BIT:   if (bit_end && bit_cnt == 3'd7) state_n = S_ACK;
      S_ACK: begin
        // ack_err already holds this slot's sample (taken at end of q2)
        if (bit_end) begin
          if (ack_err_r || byte_idx == num_r) state_n = S_STOP;
          else                                state_n = S_BIT;
        end
      end
      S_STOP:  if (bit_end) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    case (byte_idx)
      2'd0:    next_byte = d0_r;
      2'd1:    next_byte = d1_r;
      default: next_byte = d2_r;
    endcase
  end

  // Transaction datapath: captured request, bit shifter, byte/bit counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_r     <= '0;
      d0_r      <= '0;
      d1_r      <= '0;
      d2_r      <= '0;
      shift     <= '0;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      ack_err_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            num_r     <= bus.num_wr_bytes;
            d0_r      <= bus.wr_data0;
            d1_r      <= bus.wr_data1;
            d2_r      <= bus.wr_data2;
            shift     <= {bus.addr, 1'b0};
            bit_cnt   <= '0;
            byte_idx  <= '0;
            ack_err_r <= 1'b0;
          end
        end
        S_BIT: begin
          if (bit_end) begin
            shift   <= {shift[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        S_ACK: begin
          if (quarter == 2'd2 && q_end)
            ack_err_r <= ack_err_r | bus.sdata_in;
          if (state_n == S_BIT) begin
            byte_idx <= byte_idx + 2'd1;
            shift    <= next_byte;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sclk_c = 1'b1;
    sda_c  = 1'b1;
    case (state)
      S_START: begin
        sclk_c = (quarter == 2'd0);
        sda_c  = 1'b0;
      end
      S_BIT: begin
        sclk_c = quarter[1];
        sda_c  = shift[7];
      end
      S_ACK: begin
        sclk_c = quarter[1];
        sda_c  = 1'b1;
      end
      S_STOP: begin
        // SDA rises during q2 with sclk high: the STOP condition
        sclk_c = (quarter != 2'd0);
        sda_c  = quarter[1];
      end
      default: begin
        sclk_c = 1'b1;
        sda_c  = 1'b1;
      end
    endcase
  end

  assign bus.sclk       = sclk_c;
  assign bus.sdata_out  = sda_c;
  assign bus.sdata_oe_n = sda_c;
  assign bus.done       = (state == S_DONE);
  assign bus.busy       = (state != S_IDLE);
  assign bus.ack_err    = ack_err_r;

endmodule

// File: tb/tb_i2c_wr_engine.sv
// tb/tb_i2c_wr_engine.sv - self-checking bench for i2c_wr_engine (CLK_DIV_BITS=2, Q=2)
// Purpose: table of transactions plus held-start and mid-frame reset sequences;
//          a bus monitor decodes SDA bytes against a queue of expected bytes.
// Ports: none (top level).
`timescale 1ns/1ps
module tb_i2c_wr_engine;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic slave_nack = 1'b0;

  i2c_wr_engine_if bus ();
  assign bus.sdata_in = slave_nack;

  i2c_wr_engine #(.CLK_DIV_BITS(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  int cyc_ctr = 0;
  always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard and bus monitor state
  logic [7:0] exp_q[$];
  logic       mon_en = 1'b0;
  logic       in_frame = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic [8:0] shreg = '0;
  int         nbits = 0;
  int         byte_idx = 0;
  int         nack_idx = -1;
  int         start_cnt = 0;
  int         stop_cnt = 0;
  int         viol_cnt = 0;
  int         oe_mis = 0;
  int         frames = 0;
  int         stops_exp = 0;

  always @(negedge clk) begin
    logic scl;
    logic sda;
    scl = bus.sclk;
    sda = bus.sdata_out;
    if (mon_en) begin
      if (bus.sdata_oe_n !== sda) oe_mis++;
      if (sda !== prev_sda && prev_scl && scl) begin
        if (!sda) begin
          start_cnt++;
          in_frame = 1'b1;
          nbits = 0;
          byte_idx = 0;
        end else begin
          stop_cnt++;
          chk("stop_align", nbits, 1);
          in_frame = 1'b0;
          nbits = 0;
        end
      end else if (sda !== prev_sda && !prev_scl && scl) begin
        viol_cnt++;
      end
      if (in_frame && !prev_scl && scl) begin
        shreg = {shreg[7:0], sda};
        nbits++;
        if (nbits == 9) begin
          chk("ack_release", shreg[0], 1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_byte: got %02h expected none", shreg[8:1]);
          end else begin
            chk("sda_byte", shreg[8:1], exp_q.pop_front());
          end
        end
      end
      if (in_frame && prev_scl && !scl && nbits == 9) begin
        nbits = 0;
        byte_idx++;
      end
    end
    prev_scl = scl;
    prev_sda = sda;
    slave_nack = in_frame && (byte_idx == nack_idx);
  end

  typedef struct {
    logic [6:0] a;
    logic [1:0] n;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] d2;
    int         nack;
    int         cyc;
    logic       err;
  } vec_t;

  vec_t vecs[6];

  task automatic wait_done(input int acc, output int elapsed);
    while (!bus.done && (cyc_ctr - acc) < 2000) begin
      @(posedge clk);
      #1;
    end
    elapsed = cyc_ctr - acc;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    logic [7:0] fb[4];
    int nb;
    int acc;
    int el;
    @(negedge clk);
    bus.addr = v.a;
    bus.num_wr_bytes = v.n;
    bus.wr_data0 = v.d0;
    bus.wr_data1 = v.d1;
    bus.wr_data2 = v.d2;
    nack_idx = v.nack;
    fb[0] = {v.a, 1'b0};
    fb[1] = v.d0;
    fb[2] = v.d1;
    fb[3] = v.d2;
    nb = int'(v.n) + 1;
    if (v.nack >= 0 && v.nack < nb) nb = v.nack + 1;
    for (int i = 0; i < nb; i++) exp_q.push_back(fb[i]);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc_ctr;
    chk({tag, "_busy_on_accept"}, bus.busy, 1);
    chk({tag, "_ack_err_cleared"}, bus.ack_err, 0);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(acc, el);
    chk({tag, "_done_cycle"}, el, v.cyc);
    chk({tag, "_busy_at_done"}, bus.busy, 1);
    @(posedge clk);
    #1;
    chk({tag, "_done_one_cycle"}, bus.done, 0);
    chk({tag, "_busy_cleared"}, bus.busy, 0);
    chk({tag, "_bytes_left"}, exp_q.size(), 0);
    chk({tag, "_ack_err"}, bus.ack_err, v.err);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_ack_err_hold"}, bus.ack_err, v.err);
    frames++;
    stops_exp++;
  endtask

  initial begin
    int acc;
    int el;
    int k;
    vec_t rv;

    vecs[0] = '{7'h20, 2'd3, 8'h02, 8'hA5, 8'h3C, -1, 300, 1'b0};
    vecs[1] = '{7'h21, 2'd0, 8'h00, 8'h00, 8'h00, -1,  84, 1'b0};
    vecs[2] = '{7'h55, 2'd3, 8'h11, 8'h22, 8'h33,  2, 228, 1'b1};
    vecs[3] = '{7'h7F, 2'd1, 8'hFF, 8'h00, 8'h00, -1, 156, 1'b0};
    vecs[4] = '{7'h00, 2'd2, 8'h00, 8'h80, 8'h00,  0,  84, 1'b1};
    vecs[5] = '{7'h3A, 2'd2, 8'hC3, 8'h5A, 8'h00,  2, 228, 1'b1};

    bus.start = 1'b0;
    bus.addr = '0;
    bus.num_wr_bytes = '0;
    bus.wr_data0 = '0;
    bus.wr_data1 = '0;
    bus.wr_data2 = '0;

    // reset state
    #2 reset_n = 1'b0;
    #1;
    chk("rst_sclk", bus.sclk, 1);
    chk("rst_sdata_out", bus.sdata_out, 1);
    chk("rst_sdata_oe_n", bus.sdata_oe_n, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack_err", bus.ack_err, 0);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("v%0d", i));

    // start held high, re-pulsed and inputs changed while busy
    @(negedge clk);
    bus.addr = 7'h12;
    bus.num_wr_bytes = 2'd1;
    bus.wr_data0 = 8'h9C;
    bus.wr_data1 = 8'h00;
    bus.wr_data2 = 8'h00;
    nack_idx = -1;
    exp_q.push_back(8'h24);
    exp_q.push_back(8'h9C);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc_ctr;
    chk("held_busy", bus.busy, 1);
    repeat (20) @(posedge clk);
    #3;
    bus.addr = 7'h6B;
    bus.num_wr_bytes = 2'd2;
    bus.wr_data0 = 8'h11;
    bus.wr_data1 = 8'h22;
    bus.wr_data2 = 8'h33;
    bus.start = 1'b0;
    @(posedge clk);
    #3 bus.start = 1'b1;
    wait_done(acc, el);
    chk("held_f1_done_cycle", el, 156);
    exp_q.push_back(8'hD6);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    @(posedge clk);
    #1;
    chk("held_idle_gap", bus.busy, 0);
    @(posedge clk);
    #1;
    acc = cyc_ctr;
    chk("held_reaccept", bus.busy, 1);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(acc, el);
    chk("held_f2_done_cycle", el, 228);
    repeat (10) @(posedge clk);
    #1;
    chk("held_no_third", bus.busy, 0);
    chk("held_bytes_left", exp_q.size(), 0);
    frames += 2;
    stops_exp += 2;

    // reset during the second byte
    @(negedge clk);
    bus.addr = 7'h2A;
    bus.num_wr_bytes = 2'd3;
    bus.wr_data0 = 8'hF0;
    bus.wr_data1 = 8'h0F;
    bus.wr_data2 = 8'h99;
    nack_idx = -1;
    exp_q.push_back(8'h54);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'h99);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (!(byte_idx == 1 && nbits >= 3) && k < 1000) begin
      @(posedge clk);
      #3;
      k++;
    end
    chk("rst_mid_reach_byte2", (k < 1000), 1);
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_sclk", bus.sclk, 1);
    chk("rst_mid_sdata_oe_n", bus.sdata_oe_n, 1);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_done", bus.done, 0);
    exp_q.delete();
    in_frame = 1'b0;
    nbits = 0;
    frames++;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #3 mon_en = 1'b1;
    rv = '{7'h2A, 2'd3, 8'hF0, 8'h0F, 8'h99, -1, 300, 1'b0};
    run_txn(rv, "post_rst");

    chk("sda_oe_eq_out", oe_mis, 0);
    chk("sda_change_scl_high", viol_cnt, 0);
    chk("start_conditions", start_cnt, frames);
    chk("stop_conditions", stop_cnt, stops_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_wr_engine.md
I2C_WR_ENGINE -- requirements
Module: i2c_wr_engine

Interface
REQ-001 SHALL have parameter CLK_DIV_BITS, default 10, meaning I2C clock = clk / 2^(CLK_DIV_BITS+1); legal range 2..16.
REQ-002 SHALL define Q = 2^(CLK_DIV_BITS-1) clk cycles as one quarter-bit period.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 addr  input  7  target 7-bit I2C address.
REQ-006 num_wr_bytes  input  2  data bytes following the address byte, 0..3.
REQ-007 wr_data0 / wr_data1 / wr_data2  input  8 each  data bytes, sent in that order, MSB first.
REQ-008 start  input  1  transaction request, level-sampled.
REQ-009 done  output  1  one-cycle pulse marking end of transaction.
REQ-010 busy  output  1  high from accepted start until done inclusive.
REQ-011 ack_err  output  1  a NACK occurred in the most recent transaction.
REQ-012 sclk  output  1  I2C clock, push-pull.
REQ-013 sdata_out  output  1  requested SDA level.
REQ-014 sdata_oe_n  output  1  0 drives SDA low, 1 releases SDA; always equal to sdata_out (open-drain).
REQ-015 sdata_in  input  1  sampled SDA pad, used for ACK only.

Function
REQ-016 States SHALL be IDLE, START, BIT, ACK, STOP, DONE.
REQ-017 In IDLE, start=1 SHALL be accepted on that edge: addr, num_wr_bytes, wr_data0..2 captured, ack_err cleared, busy set, phase counter zeroed, go to START.
REQ-018 start SHALL be ignored whenever busy=1; later input changes SHALL not affect an accepted transaction.
REQ-019 START: 2 quarters; SDA low with sclk high for quarter 0, sclk low for quarter 1; then BIT.
REQ-020 Frame SHALL be the address byte {addr,1'b0}, then num_wr_bytes data bytes; num_wr_bytes=0 sends the address byte only.
REQ-021 Each bit SHALL span 4 quarters: q0 sclk low with SDA updated at the q0 start; q1 sclk low; q2, q3 sclk high.
REQ-022 After 8 bits: ACK state, one 4-quarter bit with SDA released; sdata_in SHALL be sampled on the last clk cycle of q2.
REQ-023 Sampled sdata_in=1 (NACK) SHALL set ack_err and go straight to STOP, skipping remaining bytes; sampled 0 continues to the next byte, or to STOP after the last byte.
REQ-024 STOP: 4 quarters; q0 sclk low/SDA low, q1 sclk high/SDA low, q2 sclk high/SDA released, q3 bus idle; then DONE.
REQ-025 DONE: done=1 for exactly one cycle, busy cleared on the following cycle, return to IDLE; start SHALL be accepted in IDLE on the cycle after DONE.
REQ-026 Without NACK, done SHALL assert exactly (6 + 36*(num_wr_bytes+1))*Q cycles after the accepting edge.
REQ-027 The phase counter SHALL wrap modulo Q with no drift; all quarters SHALL be exactly Q cycles.
REQ-028 ack_err SHALL hold its value from DONE until the next accepted start.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE: sclk=1, sdata_out=1, sdata_oe_n=1, done=0, busy=0, ack_err=0, counters cleared.
REQ-030 Reset mid-transaction SHALL abandon the frame with no STOP generated; first accepted start after release begins a fresh START.

Verification (CLK_DIV_BITS=2, Q=2)
REQ-031 addr=0x20, num=3, data 0x02,0xA5,0x3C, slave always ACKs -> SDA bytes 0x40,0x02,0xA5,0x3C; done at cycle 300; ack_err=0.
REQ-032 num=0, addr=0x21, ACK -> byte 0x42 only; done at cycle 84.
REQ-033 NACK on 2nd data byte, num=3 -> STOP follows that ACK slot; no third byte; done at cycle 228; ack_err=1 until next start.
REQ-034 start held high through the transaction and pulsed during busy -> exactly one frame per IDLE acceptance; inputs changed mid-frame have no effect on SDA.
REQ-035 reset_n low during the 2nd byte -> same cycle sclk=1, sdata_oe_n=1, busy=0; new start after release yields a correct full frame.
REQ-036 Protocol checker throughout: SDA transitions only while sclk low except START/STOP; sdata_oe_n == sdata_out always.
